// File: rtl/phase_receiver_if.sv
// Purpose : bundles the phase-strobe inputs and status outputs of phase_receiver.
// Ports   : master = controller/stimulus side (drives strobes, halt_op, clear_err);
//           slave  = receiver side (drives phase_en, phase_idx, instr_count, flags).
interface phase_receiver_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       phase_in;
  logic             halt_op;
  logic             clear_err;
  logic [4:0]       phase_en;
  logic [2:0]       phase_idx;
  logic [CNT_W-1:0] instr_count;
  logic             haltout;
  logic             busy;
  logic             error;
  logic [1:0]       err_code;

  modport master (
    output phase_in, halt_op, clear_err,
    input  phase_en, phase_idx, instr_count, haltout, busy, error, err_code
  );

  modport slave (
    input  phase_in, halt_op, clear_err,
    output phase_en, phase_idx, instr_count, haltout, busy, error, err_code
  );
endinterface

// File: rtl/phase_receiver.sv
// Purpose : checks five-phase controller strobes, emits one-hot stage enables, counts instructions.
// Latency : one clock from accepted strobe to phase_en pulse; back-to-back strobes accepted.
// Backpr. : none; strobes are never stalled, bad ones latch a sticky error until clear_err.
// Ports   : clock, reset (async active-high); bus.slave carries phase_in/halt_op/clear_err in,
//           phase_en/phase_idx/instr_count/haltout/busy/error/err_code out (all registered).
module phase_receiver #(
  parameter int CNT_W = 16
) (
  input logic             clock,
  input logic             reset,
  phase_receiver_if.slave bus
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    ERROR  = 2'd2
  } state_t;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_MULTI = 2'd1;
  localparam logic [1:0] ERR_ORDER = 2'd2;
  localparam logic [1:0] ERR_HALT  = 2'd3;

  state_t           state_q, state_d;
  logic [2:0]       exp_q, exp_d;
  logic [4:0]       phase_en_q, phase_en_d;
  logic [2:0]       phase_idx_q, phase_idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             halt_q, halt_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic [1:0]       code_q, code_d;

  logic             strobe_any;
  logic             strobe_multi;
  logic [4:0]       exp_mask;

  assign strobe_any   = (bus.phase_in != 5'd0);
  // x & (x-1) clears the lowest set bit; anything left means two or more strobes.
  assign strobe_multi = ((bus.phase_in & (bus.phase_in - 5'd1)) != 5'd0);
  assign exp_mask     = 5'd1 << exp_q;

  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    phase_en_d  = 5'd0;          // enables are single-cycle pulses
    phase_idx_d = phase_idx_q;
    cnt_d       = cnt_q;
    halt_d      = halt_q;
    err_d       = err_q;
    code_d      = code_q;

    unique case (state_q)
      RUN: begin
        if (strobe_any) begin
          if (strobe_multi) begin
            state_d = ERROR;
            err_d   = 1'b1;
            code_d  = ERR_MULTI;
          end else if (bus.phase_in == exp_mask) begin
            phase_en_d  = bus.phase_in;
            phase_idx_d = exp_q;
            if (exp_q == 3'd4) begin
              exp_d = 3'd0;
              cnt_d = cnt_q + CNT_W'(1);
              // halt_op only matters on the closing phase of an instruction.
              if (bus.halt_op) begin
                halt_d  = 1'b1;
                state_d = HALTED;
              end
            end else begin
              exp_d = exp_q + 3'd1;
            end
          end else begin
            state_d = ERROR;
            err_d   = 1'b1;
            code_d  = ERR_ORDER;
          end
        end
      end

      HALTED: begin
        if (strobe_any) begin
          state_d = ERROR;
          err_d   = 1'b1;
          code_d  = ERR_HALT;
        end
      end

      ERROR: begin
        // Strobes are dropped here; clear_err wins over any same-cycle strobe.
        if (bus.clear_err) begin
          state_d = RUN;
          exp_d   = 3'd0;
          err_d   = 1'b0;
          code_d  = ERR_NONE;
          halt_d  = 1'b0;
        end
      end

      default: begin
        state_d = RUN;
        exp_d   = 3'd0;
      end
    endcase

    busy_d = (state_d == RUN) && (exp_d != 3'd0);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      exp_q       <= 3'd0;
      phase_en_q  <= 5'd0;
      phase_idx_q <= 3'd0;
      cnt_q       <= '0;
      halt_q      <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      code_q      <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      phase_en_q  <= phase_en_d;
      phase_idx_q <= phase_idx_d;
      cnt_q       <= cnt_d;
      halt_q      <= halt_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      code_q      <= code_d;
    end
  end

  assign bus.phase_en    = phase_en_q;
  assign bus.phase_idx   = phase_idx_q;
  assign bus.instr_count = cnt_q;
  assign bus.haltout     = halt_q;
  assign bus.busy        = busy_q;
  assign bus.error       = err_q;
  assign bus.err_code    = code_q;

endmodule

// File: tb/tb_phase_receiver.sv
module tb_phase_receiver;

  localparam int CNT_W = 4;

  logic clock;
  logic reset;

  phase_receiver_if #(.CNT_W(CNT_W)) bus ();

  phase_receiver #(.CNT_W(CNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [4:0]       en;
    logic [2:0]       idx;
    logic [CNT_W-1:0] cnt;
    logic             hout;
    logic             busy;
    logic             err;
    logic [1:0]       code;
  } obs_t;

  typedef struct packed {
    logic [4:0] pin;
    logic       halt;
    logic       clr;
    obs_t       want;
  } vec_t;

  int   n_pass  = 0;
  int   n_total = 0;
  obs_t sb_q[$];
  vec_t tbl[$];

  function automatic obs_t mk_obs(input logic [4:0] en, input int idx, input int cnt,
                                  input logic hout, input logic busy, input logic err,
                                  input int code);
    obs_t o;
    o.en   = en;
    o.idx  = idx[2:0];
    o.cnt  = cnt[CNT_W-1:0];
    o.hout = hout;
    o.busy = busy;
    o.err  = err;
    o.code = code[1:0];
    return o;
  endfunction

  function automatic vec_t mk_vec(input logic [4:0] pin, input logic halt, input logic clr,
                                  input obs_t want);
    vec_t v;
    v.pin  = pin;
    v.halt = halt;
    v.clr  = clr;
    v.want = want;
    return v;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.en   = bus.phase_en;
    o.idx  = bus.phase_idx;
    o.cnt  = bus.instr_count;
    o.hout = bus.haltout;
    o.busy = bus.busy;
    o.err  = bus.error;
    o.code = bus.err_code;
    return o;
  endfunction

  task automatic compare(input string name, input obs_t got, input obs_t want);
    n_total++;
    if (got === want) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got en=%b idx=%0d cnt=%0d halt=%b busy=%b err=%b code=%0d, want en=%b idx=%0d cnt=%0d halt=%b busy=%b err=%b code=%0d",
               name, got.en, got.idx, got.cnt, got.hout, got.busy, got.err, got.code,
               want.en, want.idx, want.cnt, want.hout, want.busy, want.err, want.code);
    end
  endtask

  // Called just after a falling edge: drive, queue the expectation, clock once, check.
  task automatic step(input string name, input logic [4:0] pin, input logic halt,
                      input logic clr, input obs_t want);
    obs_t exp_o;
    bus.phase_in  = pin;
    bus.halt_op   = halt;
    bus.clear_err = clr;
    sb_q.push_back(want);
    @(posedge clock);
    #1;
    exp_o = sb_q.pop_front();
    compare(name, sample(), exp_o);
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    obs_t zero_o;
    int   cnt_exp;
    zero_o = mk_obs(5'b00000, 0, 0, 0, 0, 0, 0);

    // en, idx, cnt, haltout, busy, error, code
    // In-order sequence, strobes every other cycle.
    tbl.push_back(mk_vec(5'b00001, 0, 0, mk_obs(5'b00001, 0, 0, 0, 1, 0, 0)));
    tbl.push_back(mk_vec(5'b00000, 0, 0, mk_obs(5'b00000, 0, 0, 0, 1, 0, 0)));
    tbl.push_back(mk_vec(5'b00010, 0, 0, mk_obs(5'b00010, 1, 0, 0, 1, 0, 0)));
    tbl.push_back(mk_vec(5'b00000, 0, 0, mk_obs(5'b00000, 1, 0, 0, 1, 0, 0)));
    tbl.push_back(mk_vec(5'b00100, 0, 0, mk_obs(5'b00100, 2, 0, 0, 1, 0, 0)));
    tbl.push_back(mk_vec(5'b00000, 0, 0, mk_obs(5'b00000, 2, 0, 0, 1, 0, 0)));
    tbl.push_back(mk_vec(5'b01000, 0, 0, mk_obs(5'b01000, 3, 0, 0, 1, 0, 0)));
    tbl.push_back(mk_vec(5'b00000, 0, 0, mk_obs(5'b00000, 3, 0, 0, 1, 0, 0)));
    tbl.push_back(mk_vec(5'b10000, 0, 0, mk_obs(5'b10000, 4, 1, 0, 0, 0, 0)));
    tbl.push_back(mk_vec(5'b00000, 0, 0, mk_obs(5'b00000, 4, 1, 0, 0, 0, 0)));
    // Two strobes at once, then ignored strobe in ERROR, then clear.
    tbl.push_back(mk_vec(5'b00011, 0, 0, mk_obs(5'b00000, 4, 1, 0, 0, 1, 1)));
    tbl.push_back(mk_vec(5'b00001, 0, 0, mk_obs(5'b00000, 4, 1, 0, 0, 1, 1)));
    tbl.push_back(mk_vec(5'b00000, 0, 1, mk_obs(5'b00000, 4, 1, 0, 0, 0, 0)));
    // Out-of-order, first error held, clear beats a same-cycle strobe.
    tbl.push_back(mk_vec(5'b00001, 0, 0, mk_obs(5'b00001, 0, 1, 0, 1, 0, 0)));
    tbl.push_back(mk_vec(5'b01000, 0, 0, mk_obs(5'b00000, 0, 1, 0, 0, 1, 2)));
    tbl.push_back(mk_vec(5'b00110, 0, 0, mk_obs(5'b00000, 0, 1, 0, 0, 1, 2)));
    tbl.push_back(mk_vec(5'b00001, 0, 1, mk_obs(5'b00000, 0, 1, 0, 0, 0, 0)));
    tbl.push_back(mk_vec(5'b00001, 0, 0, mk_obs(5'b00001, 0, 1, 0, 1, 0, 0)));
    // clear_err in RUN is inert; halt_op ignored before phase 4; back-to-back strobes.
    tbl.push_back(mk_vec(5'b00010, 0, 1, mk_obs(5'b00010, 1, 1, 0, 1, 0, 0)));
    tbl.push_back(mk_vec(5'b00100, 1, 0, mk_obs(5'b00100, 2, 1, 0, 1, 0, 0)));
    tbl.push_back(mk_vec(5'b01000, 1, 0, mk_obs(5'b01000, 3, 1, 0, 1, 0, 0)));
    tbl.push_back(mk_vec(5'b10000, 1, 0, mk_obs(5'b10000, 4, 2, 1, 0, 0, 0)));
    // HALTED: idle holds, clear_err inert, strobe -> code 3, later error does not overwrite.
    tbl.push_back(mk_vec(5'b00000, 0, 0, mk_obs(5'b00000, 4, 2, 1, 0, 0, 0)));
    tbl.push_back(mk_vec(5'b00000, 0, 1, mk_obs(5'b00000, 4, 2, 1, 0, 0, 0)));
    tbl.push_back(mk_vec(5'b00001, 0, 0, mk_obs(5'b00000, 4, 2, 1, 0, 1, 3)));
    tbl.push_back(mk_vec(5'b00011, 0, 0, mk_obs(5'b00000, 4, 2, 1, 0, 1, 3)));
    tbl.push_back(mk_vec(5'b00000, 0, 1, mk_obs(5'b00000, 4, 2, 0, 0, 0, 0)));
    tbl.push_back(mk_vec(5'b00001, 0, 0, mk_obs(5'b00001, 0, 2, 0, 1, 0, 0)));
    tbl.push_back(mk_vec(5'b00010, 0, 0, mk_obs(5'b00010, 1, 2, 0, 1, 0, 0)));
    tbl.push_back(mk_vec(5'b00100, 0, 0, mk_obs(5'b00100, 2, 2, 0, 1, 0, 0)));

    reset         = 1'b1;
    bus.phase_in  = 5'b0;
    bus.halt_op   = 1'b0;
    bus.clear_err = 1'b0;
    repeat (3) @(negedge clock);
    compare("reset_state", sample(), zero_o);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      step($sformatf("vec[%0d]", i), tbl[i].pin, tbl[i].halt, tbl[i].clr, tbl[i].want);
    end

    // Mid-sequence reset (after phase 2): outputs clear without a clock edge.
    #2;
    reset = 1'b1;
    #1;
    compare("async_reset", sample(), zero_o);
    @(negedge clock);
    reset = 1'b0;
    step("post_reset_ooo", 5'b01000, 0, 0, mk_obs(5'b00000, 0, 0, 0, 0, 1, 2));
    step("post_reset_clr", 5'b00000, 0, 1, zero_o);
    step("post_reset_p0",  5'b00001, 0, 0, mk_obs(5'b00001, 0, 0, 0, 1, 0, 0));

    // Counter wrap: 17 back-to-back sequences from a fresh reset.
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    for (int s = 1; s <= 17; s++) begin
      for (int p = 0; p < 5; p++) begin
        cnt_exp = (p == 4) ? (s % 16) : ((s - 1) % 16);
        step($sformatf("wrap_s%0d_p%0d", s, p), 5'(1 << p), 0, 0,
             mk_obs(5'(1 << p), p, cnt_exp, 0, (p != 4), 0, 0));
      end
    end

    n_total++;
    if (sb_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
